// File: rtl/freq_gate_counter.sv
// Gate-window frequency counter: counts rising edges of a debounced level over
// GATE_CYCLES clocks and publishes the count with a one-cycle valid strobe.
module freq_gate_counter #(
   parameter int unsigned GATE_CYCLES = 50000000,
   parameter int unsigned GATE_W      = 26,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             iClk,
   input  logic             iReset_n,
   input  logic             iEnable,
   input  logic             iSignal,
   output logic [CNT_W-1:0] oCount,
   output logic             oValid,
   output logic             oOverflow,
   output logic             oBusy
);

   typedef enum logic {StIdle, StGate} state_e;

   localparam logic [GATE_W-1:0] LastTick = GATE_W'(GATE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [GATE_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0]  edges_q, edges_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              sat_q, sat_d;
   logic              ovf_q, ovf_d;
   logic              valid_q, valid_d;
   logic              prev_q;

   logic              rise;
   logic              final_cycle;
   logic              edges_clamp;
   logic [CNT_W-1:0]  edges_inc;

   assign rise        = iSignal & ~prev_q;
   assign final_cycle = (timer_q == LastTick);
   assign edges_clamp = rise && (edges_q == {CNT_W{1'b1}});
   assign edges_inc   = edges_clamp ? edges_q : edges_q + {{(CNT_W-1){1'b0}}, rise};

   // State register
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: dropping enable ends the window, whether or not it completes
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (iEnable)  state_d = StGate;
         StGate:  if (!iEnable) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      oBusy = (state_q == StGate);
   end

   // Window datapath: the final cycle's rise is folded into the published count
   always_comb begin
      timer_d = '0;
      edges_d = '0;
      sat_d   = 1'b0;
      count_d = count_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      if (state_q == StGate) begin
         if (final_cycle) begin
            count_d = edges_inc;
            ovf_d   = sat_q | edges_clamp;
            valid_d = 1'b1;
         end else if (iEnable) begin
            timer_d = timer_q + GATE_W'(1);
            edges_d = edges_inc;
            sat_d   = sat_q | edges_clamp;
         end
      end
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         timer_q <= '0;
         edges_q <= '0;
         sat_q   <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         prev_q  <= 1'b1;
      end else begin
         timer_q <= timer_d;
         edges_q <= edges_d;
         sat_q   <= sat_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         prev_q  <= iSignal;
      end
   end

   assign oCount    = count_q;
   assign oValid    = valid_q;
   assign oOverflow = ovf_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: a 32-bit and a 2-bit counter share one stimulus so
// window counts and saturation are checked on the same directed windows.
module tb_freq_gate_counter;

   localparam int unsigned GC = 10;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        en    = 1'b1;
   logic        sig   = 1'b1;
   logic [31:0] cnt;
   logic        valid, ovf, busy;
   logic [1:0]  cnt2;
   logic        valid2, ovf2, busy2;

   freq_gate_counter #(.GATE_CYCLES(GC), .GATE_W(4), .CNT_W(32)) u_dut (
      .iClk      (clk),
      .iReset_n  (rst_n),
      .iEnable   (en),
      .iSignal   (sig),
      .oCount    (cnt),
      .oValid    (valid),
      .oOverflow (ovf),
      .oBusy     (busy)
   );

   freq_gate_counter #(.GATE_CYCLES(GC), .GATE_W(4), .CNT_W(2)) u_dut_small (
      .iClk      (clk),
      .iReset_n  (rst_n),
      .iEnable   (en),
      .iSignal   (sig),
      .oCount    (cnt2),
      .oValid    (valid2),
      .oOverflow (ovf2),
      .oBusy     (busy2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic        v1;
      logic        v2;
      logic [31:0] cnt;
      logic        ovf;
      logic [1:0]  cnt2;
      logic        ovf2;
   } pub_t;

   typedef struct {
      logic [9:0]  sig;
      logic [31:0] cnt;
      logic        ovf;
      logic [1:0]  cnt2;
      logic        ovf2;
   } vec_t;

   pub_t got_q[$];
   pub_t exp_q[$];
   vec_t vecs[7];

   int n_chk  = 0;
   int n_fail = 0;

   // Every strobe from either DUT is logged with the cycle it appeared on
   always @(negedge clk) begin
      if (valid || valid2) got_q.push_back('{cyc, valid, valid2, cnt, ovf, cnt2, ovf2});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drives window cycles 0..n-1; bit k of s is the level during window cycle k
   task automatic drive(input logic [9:0] s, input int n, input logic last_en,
                        output int start);
      start = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (k == 0) start = cyc;
         chk($sformatf("busy_c%0d", k), {31'd0, busy}, 32'd1);
         sig = s[k];
         en  = (k == int'(GC) - 1) ? last_en : 1'b1;
      end
   endtask

   task automatic expect_pub(input int start, input logic [31:0] c, input logic o,
                             input logic [1:0] c2, input logic o2);
      exp_q.push_back('{start + int'(GC), 1'b1, 1'b1, c, o, c2, o2});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int st;
      vecs[0] = '{10'b1111111111, 32'd0, 1'b0, 2'd0, 1'b0};
      vecs[1] = '{10'b1001100110, 32'd3, 1'b0, 2'd3, 1'b0};
      vecs[2] = '{10'b1001100110, 32'd3, 1'b0, 2'd3, 1'b0};
      vecs[3] = '{10'b1000000000, 32'd1, 1'b0, 2'd1, 1'b0};
      vecs[4] = '{10'b0001010101, 32'd3, 1'b0, 2'd3, 1'b0};
      vecs[5] = '{10'b1010101011, 32'd5, 1'b0, 2'd3, 1'b1};
      vecs[6] = '{10'b1111111110, 32'd1, 1'b0, 2'd1, 1'b0};

      // Reset with signal and enable already high
      repeat (3) @(negedge clk);
      chk("rst_count", cnt, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_count2", {30'd0, cnt2}, 32'd0);
      chk("rst_busy2", {31'd0, busy2}, 32'd0);
      rst_n = 1'b1;

      // Back-to-back windows from the table
      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].sig, int'(GC), 1'b1, st);
         expect_pub(st, vecs[i].cnt, vecs[i].ovf, vecs[i].cnt2, vecs[i].ovf2);
      end

      // Abort at window cycle 5
      drive(10'b0000001010, 5, 1'b1, st);
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_valid", {31'd0, valid}, 32'd0);
      chk("abort_count", cnt, 32'd1);
      chk("abort_ovf", {31'd0, ovf}, 32'd0);
      chk("abort_count2", {30'd0, cnt2}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         sig = ~i[0];
         @(negedge clk);
         chk("idle_busy", {31'd0, busy}, 32'd0);
      end
      chk("abort_npub", got_q.size(), exp_q.size());

      // Re-enable: fresh window, enable dropped on its final cycle
      en  = 1'b1;
      sig = 1'b0;
      drive(10'b0000110011, int'(GC), 1'b0, st);
      expect_pub(st, 32'd2, 1'b0, 2'd2, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("final_off_busy", {31'd0, busy}, 32'd0);
      chk("final_off_valid", {31'd0, valid}, 32'd0);

      // Reset pulse at window cycle 6
      en  = 1'b1;
      sig = 1'b0;
      drive(10'b0000101010, 6, 1'b1, st);
      @(negedge clk);
      rst_n = 1'b0;
      sig   = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_count", cnt, 32'd0);
      chk("midrst_ovf", {31'd0, ovf}, 32'd0);
      chk("midrst_valid", {31'd0, valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("postrst_busy", {31'd0, busy}, 32'd0);
      end
      chk("midrst_npub", got_q.size(), exp_q.size());
      en = 1'b1;
      drive(10'b0000000101, int'(GC), 1'b0, st);
      expect_pub(st, 32'd1, 1'b0, 2'd1, 1'b0);
      repeat (3) @(negedge clk);

      chk("n_pub", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk($sformatf("pub%0d_cyc", i), got_q[i].cyc, exp_q[i].cyc);
         chk($sformatf("pub%0d_v", i), {30'd0, got_q[i].v1, got_q[i].v2}, 32'd3);
         chk($sformatf("pub%0d_count", i), got_q[i].cnt, exp_q[i].cnt);
         chk($sformatf("pub%0d_ovf", i), {31'd0, got_q[i].ovf}, {31'd0, exp_q[i].ovf});
         chk($sformatf("pub%0d_count2", i), {30'd0, got_q[i].cnt2}, {30'd0, exp_q[i].cnt2});
         chk($sformatf("pub%0d_ovf2", i), {31'd0, got_q[i].ovf2}, {31'd0, exp_q[i].ovf2});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
